mpi_interface: RTL and testbench

// MPI-over-Ethernet framing engine used by the shell test benches and bridge logic.

---
 rtl/mpi_interface.sv | 155 +++++++++++++++
 tb/tb_mpi_interface.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpi_interface.sv
// rtl/mpi_interface.sv - MPI-over-Ethernet framing engine: SEND header+payload, WAIT_DONE ingress match
module mpi_interface #(
  parameter logic [7:0] PKT_DATA = 8'h03,
  parameter logic [7:0] PKT_DONE = 8'h04
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [15:0] cmd_dst_rank,
  input  logic [7:0]  cmd_src_rank,
  input  logic [31:0] cmd_size,
  input  logic [47:0] cmd_mac_dst,
  input  logic [47:0] cmd_mac_src,
  input  logic [31:0] cmd_ip_dst,
  input  logic [31:0] cmd_ip_src,
  input  logic [63:0] pl_data,
  input  logic [7:0]  pl_keep,
  input  logic        pl_last,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [63:0] stream_out_data,
  output logic [7:0]  stream_out_keep,
  output logic        stream_out_last,
  output logic        stream_out_valid,
  input  logic        stream_out_ready,
  input  logic [63:0] stream_in_data,
  input  logic [7:0]  stream_in_keep,
  input  logic        stream_in_last,
  input  logic        stream_in_valid,
  output logic        stream_in_ready,
  output logic        done
);

  typedef enum logic [3:0] {
    S_IDLE, S_H0, S_H1, S_H2, S_H3, S_PAYLOAD, S_W0, S_W1, S_W2, S_WDRAIN
  } state_t;

  state_t      r_state;
  logic [15:0] r_dst_rank;
  logic [7:0]  r_src_rank;
  logic [31:0] r_size;
  logic [47:0] r_mac_dst;
  logic [47:0] r_mac_src;
  logic [31:0] r_ip_dst;
  logic [31:0] r_ip_src;
  logic [63:0] r_hdr_data;
  logic        r_hdr_valid;
  logic        r_done;
  logic        r_matched;

  logic w_in_payload;
  logic w_hdr_fire;
  logic w_pl_fire;
  logic w_in_fire;
  logic w_w0_match;
  logic w_w2_match;
  logic w_unused;

  assign w_in_payload = (r_state == S_PAYLOAD);
  assign w_hdr_fire   = r_hdr_valid && stream_out_ready;
  assign w_pl_fire    = w_in_payload && pl_valid && stream_out_ready;
  assign w_in_fire    = stream_in_valid && stream_in_ready;
  assign w_w0_match   = (stream_in_data[63:16] == r_mac_src);
  // The responder's dst_rank is our src_rank and its src_rank is our dst_rank.
  assign w_w2_match   = (stream_in_data[7:0] == PKT_DONE) &&
                        (stream_in_data[15:8] == r_dst_rank[7:0]) &&
                        (stream_in_data[31:16] == {8'h00, r_src_rank});
  assign w_unused     = ^stream_in_keep;

  assign cmd_ready        = (r_state == S_IDLE);
  assign stream_in_ready  = (r_state == S_W0) || (r_state == S_W1) ||
                            (r_state == S_W2) || (r_state == S_WDRAIN);
  assign pl_ready         = w_in_payload && stream_out_ready;
  assign stream_out_valid = w_in_payload ? pl_valid : r_hdr_valid;
  assign stream_out_data  = w_in_payload ? pl_data  : r_hdr_data;
  assign stream_out_keep  = w_in_payload ? pl_keep  : 8'hFF;
  assign stream_out_last  = w_in_payload && pl_last;
  assign done             = r_done;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_state     <= S_IDLE;
      r_dst_rank  <= '0;
      r_src_rank  <= '0;
      r_size      <= '0;
      r_mac_dst   <= '0;
      r_mac_src   <= '0;
      r_ip_dst    <= '0;
      r_ip_src    <= '0;
      r_hdr_data  <= '0;
      r_hdr_valid <= 1'b0;
      r_done      <= 1'b0;
      r_matched   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_matched <= 1'b0;
          if (cmd_valid) begin
            r_dst_rank <= cmd_dst_rank;
            r_src_rank <= cmd_src_rank;
            r_size     <= cmd_size;
            r_mac_dst  <= cmd_mac_dst;
            r_mac_src  <= cmd_mac_src;
            r_ip_dst   <= cmd_ip_dst;
            r_ip_src   <= cmd_ip_src;
            if (cmd_op) begin
              r_state <= S_W0;
            end else begin
              r_state     <= S_H0;
              r_hdr_data  <= {cmd_mac_dst, cmd_mac_src[47:32]};
              r_hdr_valid <= 1'b1;
            end
          end
        end
        S_H0: if (w_hdr_fire) begin
          r_state    <= S_H1;
          r_hdr_data <= {r_mac_src[31:0], r_ip_dst};
        end
        S_H1: if (w_hdr_fire) begin
          r_state    <= S_H2;
          r_hdr_data <= {r_ip_src, r_dst_rank, r_src_rank, PKT_DATA};
        end
        S_H2: if (w_hdr_fire) begin
          r_state    <= S_H3;
          r_hdr_data <= {r_size, 32'h0};
        end
        S_H3: if (w_hdr_fire) begin
          r_state     <= S_PAYLOAD;
          r_hdr_valid <= 1'b0;
        end
        S_PAYLOAD: if (w_pl_fire && pl_last) r_state <= S_IDLE;
        // A beat carrying last already ends the frame, so there is nothing left to drain.
        S_W0: if (w_in_fire) begin
          r_matched <= 1'b0;
          if (stream_in_last)  r_state <= S_W0;
          else if (w_w0_match) r_state <= S_W1;
          else                 r_state <= S_WDRAIN;
        end
        S_W1: if (w_in_fire) r_state <= stream_in_last ? S_W0 : S_W2;
        S_W2: if (w_in_fire) begin
          r_matched <= w_w2_match;
          r_done    <= w_w2_match;
          if (stream_in_last) r_state <= w_w2_match ? S_IDLE : S_W0;
          else                r_state <= S_WDRAIN;
        end
        S_WDRAIN: if (w_in_fire && stream_in_last) r_state <= r_matched ? S_IDLE : S_W0;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpi_interface.sv
// tb/tb_mpi_interface.sv - self-checking bench for mpi_interface: vector table, random SEND/WAIT_DONE vs frame model
module tb_mpi_interface;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [15:0] cmd_dst_rank;
  logic [7:0]  cmd_src_rank;
  logic [31:0] cmd_size;
  logic [47:0] cmd_mac_dst, cmd_mac_src;
  logic [31:0] cmd_ip_dst, cmd_ip_src;
  logic [63:0] pl_data;
  logic [7:0]  pl_keep;
  logic        pl_last, pl_valid, pl_ready;
  logic [63:0] stream_out_data;
  logic [7:0]  stream_out_keep;
  logic        stream_out_last, stream_out_valid, stream_out_ready;
  logic [63:0] stream_in_data;
  logic [7:0]  stream_in_keep;
  logic        stream_in_last, stream_in_valid, stream_in_ready;
  logic        done;

  always #5 clk = ~clk;

  mpi_interface dut (
    .clk(clk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst_rank(cmd_dst_rank), .cmd_src_rank(cmd_src_rank), .cmd_size(cmd_size),
    .cmd_mac_dst(cmd_mac_dst), .cmd_mac_src(cmd_mac_src),
    .cmd_ip_dst(cmd_ip_dst), .cmd_ip_src(cmd_ip_src),
    .pl_data(pl_data), .pl_keep(pl_keep), .pl_last(pl_last), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .stream_out_data(stream_out_data), .stream_out_keep(stream_out_keep),
    .stream_out_last(stream_out_last), .stream_out_valid(stream_out_valid),
    .stream_out_ready(stream_out_ready),
    .stream_in_data(stream_in_data), .stream_in_keep(stream_in_keep),
    .stream_in_last(stream_in_last), .stream_in_valid(stream_in_valid),
    .stream_in_ready(stream_in_ready),
    .done(done)
  );

  typedef struct { logic [63:0] data; logic [7:0] keep; logic last; } beat_t;
  typedef struct {
    logic [15:0] dst; logic [7:0] src; logic [31:0] size;
    logic [47:0] mdst; logic [47:0] msrc; logic [31:0] ipd; logic [31:0] ips;
    int n; bit rnd; logic [63:0] h0, h1, h2, h3;
  } send_vec_t;

  int checks = 0;
  int failures = 0;
  int cyc_no = 0;
  int done_cnt = 0;
  int last_cmd_cyc = 0;
  int last_beat_cyc = 0;
  bit cmd_fire, pl_fire, in_fire, out_fire, prev_stall;
  bit s_cmd_ready, s_pl_ready, s_out_valid, s_in_ready, s_done;
  beat_t prev_beat;
  beat_t got_q[$];
  beat_t pay_q[$];
  logic [63:0] fr_data[$];
  bit          fr_last[$];
  int          fr_len[$];
  send_vec_t   tv[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  // Flat 256-bit header image; beat k is bits [255-64k -: 64].
  function automatic logic [255:0] hdr_model(input logic [47:0] mdst, input logic [47:0] msrc,
                                             input logic [31:0] ipd, input logic [31:0] ips,
                                             input logic [15:0] dst, input logic [7:0] src,
                                             input logic [7:0] typ, input logic [31:0] size);
    return {mdst, msrc, ipd, ips, dst, src, typ, size, 32'h0};
  endfunction

  task automatic cyc();
    #1;
    s_cmd_ready = cmd_ready; s_pl_ready = pl_ready; s_out_valid = stream_out_valid;
    s_in_ready = stream_in_ready; s_done = done;
    if (prev_stall && aresetn) begin
      chk("hold_valid", 64'(stream_out_valid), 64'd1);
      chk("hold_data", stream_out_data, prev_beat.data);
      chk("hold_ctl", 64'({stream_out_keep, stream_out_last}), 64'({prev_beat.keep, prev_beat.last}));
    end
    prev_stall = aresetn && stream_out_valid && !stream_out_ready;
    prev_beat  = '{stream_out_data, stream_out_keep, stream_out_last};
    out_fire   = stream_out_valid && stream_out_ready;
    if (out_fire) begin
      got_q.push_back(prev_beat);
      if (stream_out_last) last_beat_cyc = cyc_no;
    end
    cmd_fire = cmd_valid && cmd_ready;
    if (cmd_fire) last_cmd_cyc = cyc_no;
    pl_fire = pl_valid && pl_ready;
    in_fire = stream_in_valid && stream_in_ready;
    if (done) done_cnt++;
    @(negedge clk);
    cyc_no++;
  endtask

  task automatic fill_payload(input int n, input bit const13);
    pay_q.delete();
    for (int k = 0; k < n; k++) begin
      if (const13) pay_q.push_back('{64'd13, 8'hFF, k == n - 1});
      else pay_q.push_back('{{$urandom, $urandom}, 8'($urandom_range(1, 255)), k == n - 1});
    end
  endtask

  task automatic issue_cmd(input bit op, input send_vec_t v);
    cmd_op = op; cmd_dst_rank = v.dst; cmd_src_rank = v.src; cmd_size = v.size;
    cmd_mac_dst = v.mdst; cmd_mac_src = v.msrc; cmd_ip_dst = v.ipd; cmd_ip_src = v.ips;
    cmd_valid = 1'b1;
    cmd_fire = 1'b0;
    for (int g = 0; g < 10 && !cmd_fire; g++) cyc();
    cmd_valid = 1'b0;
    chk("cmd_accept", 64'(cmd_fire), 64'd1);
  endtask

  task automatic do_send(input send_vec_t v, input logic [255:0] eh);
    beat_t exp_q[$];
    int pi, guard;
    for (int k = 0; k < 4; k++) exp_q.push_back('{eh[255-64*k -: 64], 8'hFF, 1'b0});
    foreach (pay_q[k]) exp_q.push_back(pay_q[k]);
    got_q.delete();
    stream_out_ready = 1'b1;
    issue_cmd(1'b0, v);
    pi = 0;
    guard = 0;
    while (guard < 3000) begin
      stream_out_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!pl_valid && pi < v.n && (!v.rnd || $urandom_range(0, 2) != 0)) begin
        pl_valid = 1'b1; pl_data = pay_q[pi].data; pl_keep = pay_q[pi].keep; pl_last = pay_q[pi].last;
      end
      cyc();
      if (pl_fire) begin pi++; pl_valid = 1'b0; end
      if (got_q.size() > 0 && got_q[$].last) break;
      guard++;
    end
    pl_valid = 1'b0; pl_last = 1'b0; stream_out_ready = 1'b1;
    cyc();
    chk("send_count", 64'(got_q.size()), 64'(exp_q.size()));
    foreach (got_q[k]) if (k < exp_q.size()) begin
      chk("send_data", got_q[k].data, exp_q[k].data);
      chk("send_ctl", 64'({got_q[k].keep, got_q[k].last}), 64'({exp_q[k].keep, exp_q[k].last}));
    end
    chk("send_idle", 64'(s_cmd_ready), 64'd1);
    if (!v.rnd) chk("send_latency", 64'(last_beat_cyc - last_cmd_cyc), 64'(4 + v.n));
  endtask

  task automatic add_frame(input logic [255:0] h, input int len);
    for (int k = 0; k < len; k++) begin
      fr_data.push_back(k < 4 ? h[255-64*k -: 64] : {$urandom, $urandom});
      fr_last.push_back(k == len - 1);
    end
    fr_len.push_back(len);
  endtask

  task automatic clear_frames();
    fr_data.delete(); fr_last.delete(); fr_len.delete();
  endtask

  task automatic do_wait(input send_vec_t v);
    int m, base, start_m, nbeats, fed, guard, done_before;
    // Frame-level reference: the first frame of >=3 beats whose beat0/beat2 fields match ends the wait.
    m = -1; base = 0; start_m = 0;
    for (int f = 0; f < fr_len.size(); f++) begin
      if (m < 0 && fr_len[f] >= 3 && fr_data[base][63:16] == v.msrc &&
          fr_data[base+2][7:0] == 8'h04 && fr_data[base+2][15:8] == v.dst[7:0] &&
          fr_data[base+2][31:16] == {8'h00, v.src}) begin
        m = f; start_m = base;
      end
      base += fr_len[f];
    end
    if (m < 0) begin m = fr_len.size() - 1; start_m = base - fr_len[m]; end
    nbeats = start_m + fr_len[m];
    issue_cmd(1'b1, v);
    done_cnt = 0; done_before = 0; fed = 0; guard = 0;
    while (fed < nbeats && guard < 3000) begin
      if (!stream_in_valid && $urandom_range(0, 3) != 0) begin
        stream_in_valid = 1'b1; stream_in_data = fr_data[fed]; stream_in_last = fr_last[fed];
      end
      cyc();
      if (in_fire) begin
        if (fed == start_m) done_before = done_cnt;
        fed++;
        stream_in_valid = 1'b0;
      end
      guard++;
    end
    stream_in_valid = 1'b0; stream_in_last = 1'b0;
    chk("wait_fed", 64'(fed), 64'(nbeats));
    repeat (3) cyc();
    chk("done_early", 64'(done_before), 64'd0);
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("wait_idle", 64'(s_cmd_ready), 64'd1);
    chk("wait_in_ready", 64'(s_in_ready), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    send_vec_t v;
    logic [255:0] hg;
    int nj, kind;
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0;
    cmd_dst_rank = '0; cmd_src_rank = '0; cmd_size = '0; cmd_mac_dst = '0; cmd_mac_src = '0;
    cmd_ip_dst = '0; cmd_ip_src = '0;
    pl_data = '0; pl_keep = '0; pl_last = 1'b0; pl_valid = 1'b0;
    stream_out_ready = 1'b1;
    stream_in_data = '0; stream_in_keep = 8'hFF; stream_in_last = 1'b0; stream_in_valid = 1'b0;
    prev_stall = 1'b0;

    tv[0] = '{16'd0, 8'd1, 32'd2, 48'hfa163e55ca02, 48'h0cc47a88c047, 32'd0, 32'd0, 11, 1'b0,
              64'hfa163e55ca020cc4, 64'h7a88c04700000000, 64'h0000000000000103, 64'h0000000200000000};
    tv[1] = '{16'h1234, 8'h56, 32'hdeadbeef, 48'h112233445566, 48'h778899aabbcc, 32'hc0a80001,
              32'hc0a80002, 3, 1'b1,
              64'h1122334455667788, 64'h99aabbccc0a80001, 64'hc0a8000212345603, 64'hdeadbeef00000000};
    tv[2] = '{16'd0, 8'd1, 32'd2, 48'hfa163e55ca02, 48'h0cc47a88c047, 32'd0, 32'd0, 1, 1'b0,
              64'hfa163e55ca020cc4, 64'h7a88c04700000000, 64'h0000000000000103, 64'h0000000200000000};

    @(negedge clk);
    cyc(); cyc();
    chk("rst_cmd_ready", 64'(s_cmd_ready), 64'd1);
    chk("rst_out_valid", 64'(s_out_valid), 64'd0);
    chk("rst_pl_ready", 64'(s_pl_ready), 64'd0);
    chk("rst_in_ready", 64'(s_in_ready), 64'd0);
    chk("rst_done", 64'(s_done), 64'd0);
    aresetn = 1'b1;
    cyc();

    for (int i = 0; i < 3; i++) begin
      fill_payload(tv[i].n, i == 0);
      do_send(tv[i], {tv[i].h0, tv[i].h1, tv[i].h2, tv[i].h3});
    end

    // Reset while payload beat 5 is on the bus.
    fill_payload(8, 1'b1);
    stream_out_ready = 1'b1;
    issue_cmd(1'b0, tv[0]);
    begin
      int pi = 0;
      for (int g = 0; g < 50 && pi < 4; g++) begin
        if (!pl_valid) begin pl_valid = 1'b1; pl_data = pay_q[pi].data; pl_keep = 8'hFF; pl_last = 1'b0; end
        cyc();
        if (pl_fire) begin pi++; pl_valid = 1'b0; end
      end
    end
    pl_valid = 1'b1; pl_data = pay_q[4].data; pl_keep = 8'hFF; pl_last = 1'b0;
    aresetn = 1'b0;
    cyc();
    aresetn = 1'b1;
    cyc();
    chk("midrst_out_valid", 64'(s_out_valid), 64'd0);
    chk("midrst_pl_ready", 64'(s_pl_ready), 64'd0);
    chk("midrst_cmd_ready", 64'(s_cmd_ready), 64'd1);
    pl_valid = 1'b0;
    cyc();

    for (int i = 0; i < 8; i++) begin
      v.dst = 16'($urandom); v.src = 8'($urandom); v.size = $urandom;
      v.mdst = {16'($urandom), $urandom}; v.msrc = {16'($urandom), $urandom};
      v.ipd = $urandom; v.ips = $urandom; v.n = $urandom_range(1, 8); v.rnd = (i % 4) != 3;
      v.h0 = '0; v.h1 = '0; v.h2 = '0; v.h3 = '0;
      fill_payload(v.n, 1'b0);
      do_send(v, hdr_model(v.mdst, v.msrc, v.ipd, v.ips, v.dst, v.src, 8'h03, v.size));
    end

    v = tv[0]; v.dst = 16'd0; v.src = 8'd1; v.msrc = 48'h0cc47a88c047;
    clear_frames();
    add_frame(hdr_model(48'h0cc47a88c047, 48'hfa163e55ca02, 32'd0, 32'd0, 16'd1, 8'd0, 8'h04, 32'd0), 4);
    do_wait(v);

    clear_frames();
    add_frame(hdr_model(48'h0cc47a88c047, 48'hfa163e55ca02, 32'd0, 32'd0, 16'd1, 8'd0, 8'h03, 32'd0), 6);
    add_frame(hdr_model(48'h0cc47a88c047, 48'hfa163e55ca02, 32'd0, 32'd0, 16'd1, 8'd0, 8'h04, 32'd0), 4);
    do_wait(v);

    for (int i = 0; i < 6; i++) begin
      v.dst = 16'($urandom); v.src = 8'($urandom); v.msrc = {16'($urandom), $urandom};
      hg = hdr_model(v.msrc, {16'($urandom), $urandom}, $urandom, $urandom,
                     {8'h00, v.src}, v.dst[7:0], 8'h04, $urandom);
      clear_frames();
      nj = $urandom_range(0, 4);
      for (int j = 0; j < nj; j++) begin
        kind = $urandom_range(0, 5);
        case (kind)
          0: add_frame({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                       $urandom_range(1, 5));
          1: add_frame({hg[255:136], 8'h03, hg[127:0]}, $urandom_range(3, 6));
          2: add_frame({hg[255:209], ~hg[208], hg[207:0]}, $urandom_range(3, 6));
          3: add_frame(hg, $urandom_range(1, 2));
          4: add_frame({hg[255:137], ~hg[136], hg[135:0]}, $urandom_range(3, 6));
          default: add_frame({hg[255:160], 8'h01, hg[151:0]}, $urandom_range(3, 6));
        endcase
      end
      add_frame(hg, $urandom_range(3, 7));
      add_frame(hg, 4);
      do_wait(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
